// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache memory responder.
// Defines the responder state machine encoding and the line-offset wrap helper.
package cache_mem_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD,
    WR,
    DONE
  } state_t;

  // Offset of beat k when the burst starts at word 'start' within the line.
  function automatic logic [OFFSET_W-1:0] wrap_offset(input logic [OFFSET_W-1:0] start,
                                                      input logic [OFFSET_W-1:0] k);
    return OFFSET_W'((32'(start) + 32'(k)) % WORDS_PER_LINE);
  endfunction

endpackage

// File: rtl/cache_mem_ram.sv
// Single-port synchronous backing RAM: one-cycle registered read, write enable,
// contents are not reset.
module cache_mem_ram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder serving 4-word line refills and writebacks from the cache.
// Optional macro CRITICAL_WORD_FIRST_EN: refill beats start at the requested offset and wrap.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 3
) (
  input  logic                clk_100,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                wdata_valid,
  input  logic [DATA_W-1:0]   wdata,
  output logic                wdata_ready,
  output logic                rdata_valid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rdata_offset,
  output logic                rdata_last,
  output logic                wr_ack,
  output logic                busy
);

  localparam int                  LINE_W    = MEM_DEPTH_LOG2 - OFFSET_W;
  localparam logic [3:0]          LAT_LAST  = 4'(LATENCY);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS_PER_LINE - 1);

  state_t                state;
  logic [3:0]            lat_cnt;
  logic [OFFSET_W-1:0]   beat;
  logic [LINE_W-1:0]     line_base;
  logic [OFFSET_W-1:0]   start_off;
  logic                  req_write_q;
  logic [OFFSET_W-1:0]   first_off;

  logic                      ram_we;
  logic [MEM_DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]         ram_wdata;
  logic [DATA_W-1:0]         ram_rdata;

  // Upper address bits alias onto the same RAM words and are dropped.
  logic addr_unused;
  assign addr_unused = ^req_addr[ADDR_W-1:MEM_DEPTH_LOG2];

`ifdef CRITICAL_WORD_FIRST_EN
  assign first_off = start_off;
`else
  logic start_unused;
  assign start_unused = ^start_off;
  assign first_off    = '0;
`endif

  // WAIT spans LATENCY+1 cycles so the beat-0 read issued in its last cycle
  // lands exactly as RD begins; RD cycles are the output beats themselves.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      beat        <= '0;
      line_base   <= '0;
      start_off   <= '0;
      req_write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            line_base   <= req_addr[MEM_DEPTH_LOG2-1:OFFSET_W];
            start_off   <= req_addr[OFFSET_W-1:0];
            req_write_q <= req_write;
            beat        <= '0;
            lat_cnt     <= '0;
            state       <= req_write ? WR : WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) state <= RD;
          else                     lat_cnt <= lat_cnt + 4'd1;
        end
        RD: begin
          beat <= beat + 1'b1;
          if (beat == LAST_BEAT) state <= DONE;
        end
        WR: begin
          if (wdata_valid) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // During RD the RAM is already fetching the following beat.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = {line_base, wrap_offset(first_off, '0)};
    ram_wdata = wdata;
    case (state)
      RD: ram_addr = {line_base, wrap_offset(first_off, beat + 1'b1)};
      WR: begin
        ram_we   = wdata_valid;
        ram_addr = {line_base, beat};
      end
      default: ;
    endcase
  end

  cache_mem_ram #(
    .DEPTH_LOG2 (MEM_DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk   (clk_100),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign wdata_ready  = (state == WR);
  assign wr_ack       = (state == DONE) && req_write_q;
  assign rdata_valid  = (state == RD);
  assign rdata        = rdata_valid ? ram_rdata : '0;
  assign rdata_offset = rdata_valid ? wrap_offset(first_off, beat) : 2'd0;
  assign rdata_last   = rdata_valid && (beat == LAST_BEAT);

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized self-checking bench for cache_mem_responder against a line-level memory model.
module tb_cache_mem_responder;

  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int MEM_DEPTH_LOG2 = 10;
  localparam int LATENCY        = 3;
  localparam int MEM_WORDS      = 1 << MEM_DEPTH_LOG2;

  logic              clk_100 = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              wdata_valid = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic              req_ready, wdata_ready, rdata_valid, rdata_last, wr_ack, busy;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rdata_offset;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  bit                known   [MEM_WORDS];
  logic [DATA_W-1:0] line_data [4];

  cache_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2), .LATENCY(LATENCY)
  ) dut (
    .clk_100(clk_100), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_offset(rdata_offset),
    .rdata_last(rdata_last), .wr_ack(wr_ack), .busy(busy)
  );

  always #5 clk_100 = ~clk_100;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line offset delivered as the k-th refill beat for a request at addr.
  function automatic int beat_order(input logic [ADDR_W-1:0] addr, input int k);
`ifdef CRITICAL_WORD_FIRST_EN
    return (int'(addr) % 4 + k) % 4;
`else
    return k;
`endif
  endfunction

  function automatic int word_index(input logic [ADDR_W-1:0] addr, input int off);
    return (int'(addr) % MEM_WORDS) / 4 * 4 + off;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 1);
    checkOutput({tag, "_rdata_valid"}, rdata_valid, 0);
    checkOutput({tag, "_rdata"}, rdata, 0);
    checkOutput({tag, "_rdata_offset"}, rdata_offset, 0);
    checkOutput({tag, "_rdata_last"}, rdata_last, 0);
    checkOutput({tag, "_wr_ack"}, wr_ack, 0);
    checkOutput({tag, "_wdata_ready"}, wdata_ready, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic applyWriteback(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data [4],
                                input int gap);
    @(negedge clk_100);
    checkOutput("wb_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
    @(negedge clk_100);
    req_valid = 1'b0; req_write = 1'b0;
    checkOutput("wb_busy", busy, 1);
    checkOutput("wb_wdata_ready", wdata_ready, 1);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk_100);
        checkOutput("wb_gap_ack", wr_ack, 0);
        checkOutput("wb_gap_wdata_ready", wdata_ready, 1);
      end
      wdata_valid = 1'b1; wdata = data[b];
      @(negedge clk_100);
      wdata_valid = 1'b0;
      ref_mem[word_index(addr, b)] = data[b];
      known[word_index(addr, b)]   = 1'b1;
      checkOutput("wb_ack", wr_ack, (b == 3));
    end
    checkOutput("wb_req_ready_low", req_ready, 0);
    @(negedge clk_100);
    checkOutput("wb_ack_pulse", wr_ack, 0);
    checkOutput("wb_req_ready_back", req_ready, 1);
  endtask

  // hold keeps req_valid asserted through the burst; pre_accepted means the
  // request was already taken on the coming edge; reset_at pulses rst_n at that cycle.
  task automatic applyRefill(input logic [ADDR_W-1:0] addr, input bit hold, input bit pre_accepted,
                             input int reset_at);
    int k, idx;
    bit exp_valid;
    if (!pre_accepted) begin
      @(negedge clk_100);
      checkOutput("rf_req_ready_idle", req_ready, 1);
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    for (int n = 0; n <= LATENCY + 6; n++) begin
      @(negedge clk_100);
      if (!hold) req_valid = 1'b0;
      wdata_valid = 1'($urandom_range(0, 1));
      wdata = 16'($urandom);
      if (n == reset_at) begin
        rst_n = 1'b0; req_valid = 1'b0; wdata_valid = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        @(negedge clk_100);
        rst_n = 1'b1;
        return;
      end
      exp_valid = (n >= LATENCY + 1) && (n <= LATENCY + 4);
      checkOutput("rf_rdata_valid", rdata_valid, exp_valid);
      checkOutput("rf_req_ready", req_ready, (n >= LATENCY + 6));
      checkOutput("rf_busy", busy, (n < LATENCY + 6));
      checkOutput("rf_wr_ack", wr_ack, 0);
      if (exp_valid) begin
        k   = n - LATENCY - 1;
        idx = word_index(addr, beat_order(addr, k));
        checkOutput("rf_rdata_offset", rdata_offset, beat_order(addr, k));
        checkOutput("rf_rdata_last", rdata_last, (k == 3));
        if (known[idx]) checkOutput("rf_rdata", rdata, ref_mem[idx]);
      end
    end
    wdata_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] addr;
    for (int i = 0; i < MEM_WORDS; i++) known[i] = 1'b0;

    #2 rst_n = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (2) @(negedge clk_100);
    rst_n = 1'b1;

    $display("[TB] directed: writeback then refill of 0xF004");
    line_data = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    applyWriteback(16'hF004, line_data, 0);
    applyRefill(16'hF004, 1'b0, 1'b0, -1);
    applyRefill(16'hF006, 1'b0, 1'b0, -1);

    $display("[TB] directed: writeback with 2-cycle gaps");
    line_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    applyWriteback(16'h1230, line_data, 2);
    applyRefill(16'h1231, 1'b0, 1'b0, -1);

    $display("[TB] directed: request held during burst");
    applyRefill(16'hF005, 1'b1, 1'b0, -1);
    applyRefill(16'hF005, 1'b0, 1'b1, -1);

    $display("[TB] directed: reset during RD beat 2");
    applyRefill(16'hF004, 1'b0, 1'b0, LATENCY + 3);
    applyRefill(16'hF004, 1'b0, 1'b0, -1);

    $display("[TB] directed: address alias");
    line_data = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
    applyWriteback(16'h0004, line_data, 0);
    applyRefill(16'hFC04, 1'b0, 1'b0, -1);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      addr = {6'($urandom_range(0, 63)), 8'($urandom_range(8, 13)), 2'($urandom_range(0, 3))};
      if (!known[word_index(addr, 0)] || $urandom_range(0, 2) == 0) begin
        for (int b = 0; b < 4; b++) line_data[b] = 16'($urandom);
        applyWriteback(addr, line_data, $urandom_range(0, 2));
      end else begin
        applyRefill(addr, 1'b0, 1'b0, -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
